tl_hdr_parse: RTL
=================

TL_HDR_PARSE -- requirements
Module: tl_hdr_parse

Interface
REQ-001 SHALL have parameter TAG_W, default 8, meaning the width of the tag field.
REQ-002 SHALL have parameter MAX_PAYLOAD_BYTES, default 256, meaning the largest legal received payload.
REQ-003 SHALL have ports, one per line:
 - clk  in  1  clock.
 - rst_n  in  1  reset, asynchronous, active-low.
 - hdr_i  in  128  received 3DW header; DW0=[127:96], DW1=[95:64], DW2=[63:32], [31:0] ignored.
 - hdr_valid_i  in  1  header valid.
 - hdr_ready_o  out  1  header accepted when valid&&ready.
 - out_valid_o  out  1  decoded header valid.
 - out_ready_i  in  1  downstream accept.
 - out_kind_o  out  2  00 MRd, 01 MWr, 10 Cpl, 11 CplD.
 - out_len_dw_o  out  11  length in DW, 1..1024.
 - out_id_o  out  16  requester ID (requests) or completer ID (completions).
 - out_tag_o  out  TAG_W  tag.
 - out_addr_o  out  32  request address, [1:0]=0.
 - out_be_o  out  8  {LBE,FBE}.
 - out_status_o  out  3  completion status.
 - out_byte_cnt_o  out  13  completion byte count, 1..4096.
 - out_lower_addr_o  out  7  completion lower address.
 - tag_free_o  out  1  one-cycle tag release pulse to the tag table.
 - tag_free_id_o  out  TAG_W  tag being released.
 - cred_p_o / cred_np_o / cred_cpl_o  out  1 each  one-cycle header credit return pulses.
 - cred_data_o  out  9  data credits returned with the pulse, ceil(len_dw/4), else 0.
 - err_malformed_o  out  1  one-cycle malformed-header pulse.
 - err_unsup_o  out  1  one-cycle unsupported-type pulse.

Function
REQ-004 Field decode SHALL be: fmt=[127:125], type=[124:120], len=[105:96]; requests: req_id=[95:80], tag=[79:72], LBE=[71:68], FBE=[67:64], addr=[63:34]; completions: cpl_id=[95:80], status=[79:77], bc=[75:64], req tag=[47:40], lower_addr=[38:32].
REQ-005 Kind SHALL be: fmt 000/type 00000 MRd; 010/00000 MWr; 000/01010 Cpl; 010/01010 CplD; any other combination is unsupported.
REQ-006 Encoded len 0 SHALL decode to 1024 DW and encoded bc 0 to 4096; Cpl SHALL report len_dw 0.
REQ-007 MWr or CplD with len_dw*4 > MAX_PAYLOAD_BYTES SHALL be malformed; MRd length SHALL NOT be checked.
REQ-008 The FSM SHALL have states IDLE, CHECK, OUT, DROP.
REQ-009 IDLE: hdr_ready_o=1; on valid&&ready the header SHALL be registered -> CHECK; all other states SHALL hold hdr_ready_o=0.
REQ-010 CHECK (one cycle): legal -> OUT; unsupported or malformed -> DROP.
REQ-011 OUT: out_valid_o=1 with fields stable until out_ready_i; on handshake -> IDLE; first out_valid_o SHALL occur 2 cycles after header acceptance.
REQ-012 DROP (one cycle): assert err_unsup_o (priority) or err_malformed_o -> IDLE; nothing SHALL be presented on out_*.
REQ-013 Credit pulses SHALL fire in the out handshake cycle or the DROP cycle: MWr -> cred_p_o, MRd -> cred_np_o, Cpl/CplD -> cred_cpl_o, with cred_data_o=ceil(len_dw/4) for MWr/CplD; unsupported headers SHALL return no credit.
REQ-014 In the Cpl/CplD out handshake cycle, tag_free_o SHALL pulse with tag_free_id_o=tag when status!=000, or kind=Cpl, or bc<=len_dw*4-lower_addr[1:0]; otherwise no release.
REQ-015 Only one header SHALL be in flight; back-to-back accepts SHALL be spaced by at least 3 cycles.

Reset
REQ-016 While rst_n=0: state IDLE, hdr_ready_o=0, out_valid_o=0, all pulses 0, registered fields 0; hdr_ready_o SHALL rise the first clock after release.
REQ-017 Reset mid-OUT SHALL discard the header with no credit, tag or error pulse.

Verification
REQ-018 MWr len=4, addr=0x1000_0010, FBE=F, LBE=F -> kind 01, out_addr 0x1000_0010, out_valid 2 cycles after accept, cred_p_o with cred_data_o=1.
REQ-019 CplD tag=0x5A, len=8, bc=32, lower_addr=0 -> tag_free_o with id 0x5A and cred_cpl_o with data 2 at handshake; same with bc=64 -> no tag_free_o.
REQ-020 MWr len=65 with MAX_PAYLOAD_BYTES=256 -> err_malformed_o 2 cycles after accept, cred_p_o data 17, no out_valid_o.
REQ-021 fmt 001/type 00100 -> err_unsup_o, no credit pulse, hdr_ready_o back high the next cycle.
REQ-022 MRd with out_ready_i held low 10 cycles -> fields stable, hdr_ready_o=0 throughout, cred_np_o exactly once at handshake.

Source files
------------

// File: rtl/tl_hdr_parse.sv
// tl_hdr_parse: decodes one received 3DW TLP header at a time into request/completion fields,
// returning header/data credits, releasing completed tags and flagging bad headers.
module tl_hdr_parse #(
    parameter int TAG_W             = 8,
    parameter int MAX_PAYLOAD_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [127:0]      hdr_i,
    input  logic              hdr_valid_i,
    output logic              hdr_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [1:0]        out_kind_o,
    output logic [10:0]       out_len_dw_o,
    output logic [15:0]       out_id_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic [31:0]       out_addr_o,
    output logic [7:0]        out_be_o,
    output logic [2:0]        out_status_o,
    output logic [12:0]       out_byte_cnt_o,
    output logic [6:0]        out_lower_addr_o,
    output logic              tag_free_o,
    output logic [TAG_W-1:0]  tag_free_id_o,
    output logic              cred_p_o,
    output logic              cred_np_o,
    output logic              cred_cpl_o,
    output logic [8:0]        cred_data_o,
    output logic              err_malformed_o,
    output logic              err_unsup_o
);
    typedef enum logic [1:0] {IDLE, CHECK, OUT, DROP} state_t;
    localparam logic [31:0] MAX_PB = MAX_PAYLOAD_BYTES;
    state_t           r_state;
    logic [127:32]    r_hdr;
    logic             r_hdr_ready, r_out_valid, r_unsup, r_tag_rel;
    logic             r_cred_p, r_cred_np, r_cred_cpl;
    logic [8:0]       r_cred_data;
    logic [1:0]       r_kind;
    logic [10:0]      r_len_dw;
    logic [15:0]      r_id;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_addr;
    logic [7:0]       r_be;
    logic [2:0]       r_status;
    logic [12:0]      r_bc;
    logic [6:0]       r_la;
    logic             w_mrd, w_mwr, w_cpl, w_cpld, w_comp, w_unsup, w_mal, w_rel;
    logic             w_fire, w_drop, w_ret, w_unused;
    logic [10:0]      w_len_dw;
    logic [12:0]      w_bytes, w_bc;
    logic [8:0]       w_cred;

    assign w_mrd    = r_hdr[127:120] == 8'b000_00000;
    assign w_mwr    = r_hdr[127:120] == 8'b010_00000;
    assign w_cpl    = r_hdr[127:120] == 8'b000_01010;
    assign w_cpld   = r_hdr[127:120] == 8'b010_01010;
    assign w_comp   = w_cpl || w_cpld;
    assign w_unsup  = !(w_mrd || w_mwr || w_comp);
    assign w_len_dw = (r_hdr[105:96] == 10'd0) ? 11'd1024 : {1'b0, r_hdr[105:96]};
    assign w_bytes  = {w_len_dw, 2'b00};
    assign w_bc     = (r_hdr[75:64] == 12'd0) ? 13'd4096 : {1'b0, r_hdr[75:64]};
    assign w_mal    = (w_mwr || w_cpld) && ({19'd0, w_bytes} > MAX_PB);
    assign w_cred   = (w_mwr || w_cpld) ? 9'((w_len_dw + 11'd3) >> 2) : 9'd0;
    // A completion ends its tag when it errors, carries no data, or its bytes reach the end of the request
    assign w_rel    = (r_hdr[79:77] != 3'd0) || w_cpl || (w_bc <= w_bytes - {11'd0, r_hdr[33:32]});
    assign w_unused = ^{hdr_i[31:0], r_hdr[119:106]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hdr       <= '0;
            r_hdr_ready <= 1'b0;
            r_out_valid <= 1'b0;
            r_unsup     <= 1'b0;
            r_tag_rel   <= 1'b0;
            r_cred_p    <= 1'b0;
            r_cred_np   <= 1'b0;
            r_cred_cpl  <= 1'b0;
            r_cred_data <= '0;
            r_kind      <= '0;
            r_len_dw    <= '0;
            r_id        <= '0;
            r_tag       <= '0;
            r_addr      <= '0;
            r_be        <= '0;
            r_status    <= '0;
            r_bc        <= '0;
            r_la        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (hdr_valid_i && r_hdr_ready) begin
                        r_hdr       <= hdr_i[127:32];
                        r_hdr_ready <= 1'b0;
                        r_state     <= CHECK;
                    end else begin
                        r_hdr_ready <= 1'b1;
                    end
                end
                CHECK: begin
                    r_cred_p    <= w_mwr;
                    r_cred_np   <= w_mrd;
                    r_cred_cpl  <= w_comp;
                    r_cred_data <= w_cred;
                    r_unsup     <= w_unsup;
                    if (w_unsup || w_mal) begin
                        r_state <= DROP;
                    end else begin
                        r_state     <= OUT;
                        r_out_valid <= 1'b1;
                        r_kind      <= {w_comp, w_mwr || w_cpld};
                        r_len_dw    <= w_cpl ? 11'd0 : w_len_dw;
                        r_id        <= r_hdr[95:80];
                        r_tag       <= w_comp ? r_hdr[40 +: TAG_W] : r_hdr[72 +: TAG_W];
                        r_addr      <= w_comp ? 32'd0 : {r_hdr[63:34], 2'b00};
                        r_be        <= w_comp ? 8'd0 : r_hdr[71:64];
                        r_status    <= w_comp ? r_hdr[79:77] : 3'd0;
                        r_bc        <= w_comp ? w_bc : 13'd0;
                        r_la        <= w_comp ? r_hdr[38:32] : 7'd0;
                        r_tag_rel   <= w_comp && w_rel;
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_hdr_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                DROP: begin
                    r_hdr_ready <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign w_fire = r_out_valid && out_ready_i;
    assign w_drop = r_state == DROP;
    assign w_ret  = w_fire || w_drop;

    assign hdr_ready_o      = r_hdr_ready;
    assign out_valid_o      = r_out_valid;
    assign out_kind_o       = r_kind;
    assign out_len_dw_o     = r_len_dw;
    assign out_id_o         = r_id;
    assign out_tag_o        = r_tag;
    assign out_addr_o       = r_addr;
    assign out_be_o         = r_be;
    assign out_status_o     = r_status;
    assign out_byte_cnt_o   = r_bc;
    assign out_lower_addr_o = r_la;
    assign tag_free_o       = w_fire && r_tag_rel;
    assign tag_free_id_o    = r_tag;
    assign cred_p_o         = w_ret && r_cred_p;
    assign cred_np_o        = w_ret && r_cred_np;
    assign cred_cpl_o       = w_ret && r_cred_cpl;
    assign cred_data_o      = w_ret ? r_cred_data : 9'd0;
    assign err_unsup_o      = w_drop && r_unsup;
    assign err_malformed_o  = w_drop && !r_unsup;
endmodule
